// File: rtl/counter_btn_cond.sv
// Push-button conditioning for counter_top: two-flop sync, per-channel
// debounce, rising-edge detect and rst > stop > start command resolution.
module counter_btn_cond #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned DEB_W      = $clog2(DEB_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_i,
  input  logic       btn_stop_i,
  input  logic       btn_rst_i,
  output logic       cnt_start,
  output logic       cnt_stop,
  output logic       cnt_rst,
  output logic [2:0] btn_level
);

  // Channel order inside the packed vectors matches btn_level: {rst, stop, start}.
  localparam int unsigned ChStart = 0;
  localparam int unsigned ChStop  = 1;
  localparam int unsigned ChRst   = 2;

  localparam logic [DEB_W-1:0] DcntMax = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] DcntOne = DEB_W'(1);

  logic [2:0]            btn_raw;
  logic [2:0]            s1;
  logic [2:0]            s2;
  logic [2:0]            lvl;
  logic [2:0]            lvl_nxt;
  logic [2:0]            rise;
  logic [2:0][DEB_W-1:0] dcnt;
  logic [2:0][DEB_W-1:0] dcnt_nxt;
  logic                  start_cmd;
  logic                  stop_cmd;
  logic                  rst_cmd;

  assign btn_raw = {btn_rst_i, btn_stop_i, btn_start_i};

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Debounce: count consecutive disagreeing samples, any agreeing sample restarts.
  always_comb begin
    lvl_nxt  = lvl;
    dcnt_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      if (s2[i] != lvl[i]) begin
        if (dcnt[i] == DcntMax) begin
          lvl_nxt[i] = s2[i];
        end else begin
          dcnt_nxt[i] = dcnt[i] + DcntOne;
        end
      end
    end
  end

  // Debounced level and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl  <= '0;
      dcnt <= '0;
    end else begin
      lvl  <= lvl_nxt;
      dcnt <= dcnt_nxt;
    end
  end

  assign rise = lvl_nxt & ~lvl;

  // Priority resolution against the new debounced levels; losers are dropped.
  always_comb begin
    rst_cmd   = rise[ChRst];
    stop_cmd  = rise[ChStop] & ~rise[ChRst] & ~lvl_nxt[ChRst];
    start_cmd = rise[ChStart] & ~rise[ChStop] & ~rise[ChRst]
              & ~lvl_nxt[ChRst] & ~lvl_nxt[ChStop];
  end

  // Registered command pulses so counter_top sees glitch-free inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_start <= 1'b0;
      cnt_stop  <= 1'b0;
      cnt_rst   <= 1'b0;
    end else begin
      cnt_start <= start_cmd;
      cnt_stop  <= stop_cmd;
      cnt_rst   <= rst_cmd;
    end
  end

  assign btn_level = lvl;

endmodule
